get_field_pipe: RTL and testbench
=================================

// Module: get_field_pipe
// PURPOSE
// Registered extractor for the action/match pipeline: pulls a GET_DATA_WIDTH field from bit GET_ADDR_OFFSET
// of the first (SOP) beat of each Avalon-ST packet and presents it, with a masked-match flag, beside every
// beat of that packet. Data passes through unmodified behind a 1-cycle register + skid buffer (full throughput,
// registered in_ready). Read-side counterpart of set_field_async; sits ahead of the rewrite stages.
// PARAMETERS
// AVST_DATA_WIDTH  600  beat width, bits
// EMPTY_WIDTH      7    width of empty field
// GET_DATA_WIDTH   8    extracted field width
// GET_ADDR_OFFSET  0    LSB of field in beat; elaboration error if GET_ADDR_OFFSET+GET_DATA_WIDTH > AVST_DATA_WIDTH
// CNT_WIDTH        32   statistics counter width
// PORTS
// clk              in   1                clock; all logic on rising edge
// rst              in   1                reset; asynchronous, active-high
// in_data          in   AVST_DATA_WIDTH  input beat
// in_empty         in   EMPTY_WIDTH      unused bytes on EOP beat
// in_valid/in_ready  in/out  1           input handshake
// in_sop/in_eop    in   1                packet delimiters
// match_value      in   GET_DATA_WIDTH   compare value, sampled on accepted SOP beat
// match_mask       in   GET_DATA_WIDTH   1 = bit compared, sampled on accepted SOP beat
// out_data/out_empty/out_sop/out_eop  out  as input   registered copy of accepted beat
// out_valid/out_ready  out/in  1         output handshake
// get_data         out  GET_DATA_WIDTH   field of current packet, aligned to out beat
// get_valid        out  1                get_data/get_hit meaningful for this out beat
// get_hit          out  1                ((field ^ match_value) & match_mask) == 0
// proto_err        out  1                1-cycle pulse on delimiter violation
// pkt_count/hit_count  out  CNT_WIDTH    accepted SOP beats / SOP beats with hit; saturating
// BEHAVIOUR
// - Reset (async assert): out_valid=0, in_ready=0, skid empty, state IDLE, get_data=0, get_valid=0,
//   get_hit=0, proto_err=0, counters 0. in_ready rises 1 cycle after rst deasserts.
// - Transfer when valid&&ready. Latency: accepted beat appears on out_* next cycle when out stage empty or draining.
// - in_ready is a register: in_ready = !skid_valid. If out stage holds a beat with out_ready=0 and a new beat is
//   accepted, it goes to skid; in_ready drops next cycle. Skid drains to out stage first (order preserved).
//   out_valid only drops when both stages empty. out_* and get_* stable while out_valid&&!out_ready.
// - State machine on accepted input beats:
//   IDLE: sop -> capture field, get_valid=1; eop also -> stay IDLE, else -> IN_PKT.
//         !sop -> beat forwarded, get_valid=0, get_hit=0, get_data=0, proto_err pulse.
//   IN_PKT: !sop -> beat carries held field/hit, get_valid=1; eop -> IDLE.
//           sop -> proto_err pulse, treated as new packet (recapture, count), eop rules as IDLE.
// - Field = in_data[GET_ADDR_OFFSET+GET_DATA_WIDTH-1:GET_ADDR_OFFSET]; hit computed at capture,
//   later changes of match_value/mask do not affect the held packet. match_mask=0 -> always hit.
// - Field/hit travel with each beat through out and skid stages (per-stage copies, not one shared register).
// - pkt_count +1 per accepted SOP; hit_count +1 if hit; both hold at all-ones (no wrap).
// - Single-beat packet (sop&&eop): captured, counted, state remains IDLE.
// - rst asserted mid-packet: everything above returns to reset values at once; partial packet dropped.
// TESTING
// 1. Reset then 3-beat pkt, OFFSET=0, beat0[7:0]=8'h11, mask=FF value=11, out_ready=1 -> out 1 cycle later,
//    get_data=11, get_hit=1, get_valid=1 on all 3 beats; pkt_count=1, hit_count=1.
// 2. Same packet with value=22 mask=F0 then value=11 mask=0F -> hit=0 then hit=1; mask=00 -> hit=1.
// 3. Back-to-back 1-beat pkts, out_ready toggling 1/0 each cycle -> no beat lost/duplicated, order kept,
//    in_ready low at most while skid full, out_* stable during stall.
// 4. Non-SOP beat in IDLE -> forwarded with get_valid=0, proto_err=1 one cycle; SOP inside packet ->
//    proto_err=1, field recaptured, pkt_count+1.
// 5. Preload counters near max (CNT_WIDTH=4, 20 hit pkts) -> both read 4'hF; rst mid-packet -> out_valid=0,
//    counters 0, next SOP accepted normally.

Source files
------------

// File: rtl/get_field_pipe.sv
// Extracts a field from the SOP beat of each Avalon-ST packet and tags every beat of that packet with it
// plus a masked-match flag; 1-cycle latency, full throughput via skid buffer, registered in_ready.
module get_field_pipe #(
    parameter int AVST_DATA_WIDTH = 600,
    parameter int EMPTY_WIDTH     = 7,
    parameter int GET_DATA_WIDTH  = 8,
    parameter int GET_ADDR_OFFSET = 0,
    parameter int CNT_WIDTH       = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [AVST_DATA_WIDTH-1:0] in_data,
    input  logic [EMPTY_WIDTH-1:0]     in_empty,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       in_sop,
    input  logic                       in_eop,
    input  logic [GET_DATA_WIDTH-1:0]  match_value,
    input  logic [GET_DATA_WIDTH-1:0]  match_mask,
    output logic [AVST_DATA_WIDTH-1:0] out_data,
    output logic [EMPTY_WIDTH-1:0]     out_empty,
    output logic                       out_sop,
    output logic                       out_eop,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [GET_DATA_WIDTH-1:0]  get_data,
    output logic                       get_valid,
    output logic                       get_hit,
    output logic                       proto_err,
    output logic [CNT_WIDTH-1:0]       pkt_count,
    output logic [CNT_WIDTH-1:0]       hit_count
);

    generate
        if (GET_ADDR_OFFSET + GET_DATA_WIDTH > AVST_DATA_WIDTH) begin : g_bad_field
            $error("get_field_pipe: field extends beyond the beat");
        end
    endgenerate

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic {S_IDLE, S_IN_PKT} state_t;

    // One beat plus its field annotation; out and skid stages each hold a full copy.
    typedef struct packed {
        logic [AVST_DATA_WIDTH-1:0] data;
        logic [EMPTY_WIDTH-1:0]     empty;
        logic                       sop;
        logic                       eop;
        logic                       gvld;
        logic [GET_DATA_WIDTH-1:0]  gdat;
        logic                       ghit;
    } beat_t;

    state_t                      r_state;
    state_t                      w_state_nxt;
    logic [GET_DATA_WIDTH-1:0]   r_held_field;
    logic                        r_held_hit;
    logic                        r_perr;
    logic [CNT_WIDTH-1:0]        r_pkt_count;
    logic [CNT_WIDTH-1:0]        r_hit_count;

    beat_t                       r_out;
    logic                        r_out_vld;
    beat_t                       r_skid;
    logic                        r_skid_vld;
    logic                        r_in_ready;

    logic                        w_acc;
    logic                        w_out_free;
    logic                        w_skid_vld_nxt;
    logic [GET_DATA_WIDTH-1:0]   w_field;
    logic                        w_hit;
    logic                        w_capture;
    logic                        w_perr;
    beat_t                       w_beat;

    assign w_acc      = in_valid && r_in_ready;
    assign w_out_free = !r_out_vld || out_ready;
    assign w_field    = in_data[GET_ADDR_OFFSET +: GET_DATA_WIDTH];
    assign w_hit      = ((w_field ^ match_value) & match_mask) == '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_perr      = 1'b0;
        w_beat.data  = in_data;
        w_beat.empty = in_empty;
        w_beat.sop   = in_sop;
        w_beat.eop   = in_eop;
        w_beat.gvld  = 1'b0;
        w_beat.gdat  = '0;
        w_beat.ghit  = 1'b0;
        if (w_acc) begin
            if (in_sop) begin
                // An SOP inside a packet restarts the packet rather than being dropped.
                w_capture   = 1'b1;
                w_perr      = (r_state == S_IN_PKT);
                w_beat.gvld = 1'b1;
                w_beat.gdat = w_field;
                w_beat.ghit = w_hit;
                w_state_nxt = in_eop ? S_IDLE : S_IN_PKT;
            end else if (r_state == S_IDLE) begin
                w_perr = 1'b1;
            end else begin
                w_beat.gvld = 1'b1;
                w_beat.gdat = r_held_field;
                w_beat.ghit = r_held_hit;
                if (in_eop) begin
                    w_state_nxt = S_IDLE;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_held_field <= '0;
            r_held_hit   <= 1'b0;
            r_perr       <= 1'b0;
            r_pkt_count  <= '0;
            r_hit_count  <= '0;
        end else begin
            r_perr <= w_perr;
            if (w_capture) begin
                r_held_field <= w_field;
                r_held_hit   <= w_hit;
                if (r_pkt_count != '1) begin
                    r_pkt_count <= r_pkt_count + CNT_ONE;
                end
                if (w_hit && (r_hit_count != '1)) begin
                    r_hit_count <= r_hit_count + CNT_ONE;
                end
            end
        end
    end

    // in_ready only accepts while the skid is empty, so skid and input never compete.
    assign w_skid_vld_nxt = w_out_free ? 1'b0 : (r_skid_vld || w_acc);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out      <= '0;
            r_out_vld  <= 1'b0;
            r_skid     <= '0;
            r_skid_vld <= 1'b0;
            r_in_ready <= 1'b0;
        end else begin
            if (w_out_free) begin
                if (r_skid_vld) begin
                    r_out     <= r_skid;
                    r_out_vld <= 1'b1;
                end else if (w_acc) begin
                    r_out     <= w_beat;
                    r_out_vld <= 1'b1;
                end else begin
                    r_out_vld <= 1'b0;
                end
            end else if (w_acc) begin
                r_skid <= w_beat;
            end
            r_skid_vld <= w_skid_vld_nxt;
            r_in_ready <= !w_skid_vld_nxt;
        end
    end

    assign in_ready  = r_in_ready;
    assign out_data  = r_out.data;
    assign out_empty = r_out.empty;
    assign out_sop   = r_out.sop;
    assign out_eop   = r_out.eop;
    assign out_valid = r_out_vld;
    assign get_data  = r_out.gdat;
    assign get_valid = r_out.gvld;
    assign get_hit   = r_out.ghit;
    assign proto_err = r_perr;
    assign pkt_count = r_pkt_count;
    assign hit_count = r_hit_count;

endmodule

// File: tb/tb_get_field_pipe.sv
// Randomized and directed bench for get_field_pipe: a packet-level model predicts each output beat into a
// scoreboard queue; a negedge monitor pops and compares, and also checks stall stability.
module tb_get_field_pipe;
    localparam int DW = 600;
    localparam int EW = 7;
    localparam int GW = 8;
    localparam int OFF = 0;
    localparam int CW = 4;
    localparam int CMAX = 15;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [EW-1:0] empty;
        logic          sop;
        logic          eop;
        logic          gvld;
        logic [GW-1:0] gdat;
        logic          ghit;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] in_data = '0;
    logic [EW-1:0] in_empty = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          in_sop = 1'b0;
    logic          in_eop = 1'b0;
    logic [GW-1:0] match_value = '0;
    logic [GW-1:0] match_mask = '0;
    logic [DW-1:0] out_data;
    logic [EW-1:0] out_empty;
    logic          out_sop;
    logic          out_eop;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [GW-1:0] get_data;
    logic          get_valid;
    logic          get_hit;
    logic          proto_err;
    logic [CW-1:0] pkt_count;
    logic [CW-1:0] hit_count;

    get_field_pipe #(
        .AVST_DATA_WIDTH(DW), .EMPTY_WIDTH(EW), .GET_DATA_WIDTH(GW),
        .GET_ADDR_OFFSET(OFF), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_empty(in_empty), .in_valid(in_valid), .in_ready(in_ready),
        .in_sop(in_sop), .in_eop(in_eop), .match_value(match_value), .match_mask(match_mask),
        .out_data(out_data), .out_empty(out_empty), .out_sop(out_sop), .out_eop(out_eop),
        .out_valid(out_valid), .out_ready(out_ready),
        .get_data(get_data), .get_valid(get_valid), .get_hit(get_hit), .proto_err(proto_err),
        .pkt_count(pkt_count), .hit_count(hit_count)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];
    int   ready_mode = 0;

    // Packet-level reference state
    bit          m_inpkt = 0;
    logic [GW-1:0] m_field = '0;
    bit          m_hit = 0;
    int          m_pkt = 0;
    int          m_hits = 0;
    bit          exp_perr = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] d;
        d = '0;
        for (int i = 0; i < DW; i += 32) d = (d << 32) | DW'($urandom);
        return d;
    endfunction

    function automatic int sat_inc(input int v);
        return (v >= CMAX) ? CMAX : v + 1;
    endfunction

    // Model of one accepted beat, applied from the packet rules.
    function automatic exp_t model_accept(input logic [DW-1:0] d, input logic [EW-1:0] e,
                                          input bit sop, input bit eop,
                                          input logic [GW-1:0] mv, input logic [GW-1:0] mm);
        exp_t x;
        logic [GW-1:0] f;
        x.data = d; x.empty = e; x.sop = sop; x.eop = eop;
        x.gvld = 0; x.gdat = '0; x.ghit = 0;
        f = d[OFF +: GW];
        exp_perr = 0;
        if (sop) begin
            exp_perr = m_inpkt;
            m_field = f;
            m_hit = ((f ^ mv) & mm) == 0;
            m_pkt = sat_inc(m_pkt);
            if (m_hit) m_hits = sat_inc(m_hits);
            m_inpkt = !eop;
            x.gvld = 1; x.gdat = f; x.ghit = m_hit;
        end else if (!m_inpkt) begin
            exp_perr = 1;
        end else begin
            x.gvld = 1; x.gdat = m_field; x.ghit = m_hit;
            if (eop) m_inpkt = 0;
        end
        return x;
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
        chk("proto_err", 32'(proto_err), 32'(exp_perr));
        chk("pkt_count", 32'(pkt_count), 32'(m_pkt));
        chk("hit_count", 32'(hit_count), 32'(m_hits));
        exp_perr = 0;
    endtask

    task automatic send_beat(input logic [DW-1:0] d, input bit sop, input bit eop,
                             input logic [GW-1:0] mv, input logic [GW-1:0] mm);
        bit done;
        done = 0;
        in_data = d; in_empty = EW'($urandom); in_sop = sop; in_eop = eop;
        match_value = mv; match_mask = mm; in_valid = 1;
        for (int t = 0; t < 50 && !done; t++) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back(model_accept(d, in_empty, sop, eop, mv, mm));
                done = 1;
            end
            cycle();
        end
        if (!done) chk("in_ready_timeout", 32'(0), 32'(1));
        in_valid = 0;
    endtask

    task automatic idle(input int n);
        in_valid = 0;
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic drain();
        in_valid = 0;
        for (int i = 0; i < 100 && sb.size() != 0; i++) cycle();
        chk("drain_empty", 32'(sb.size()), 32'(0));
    endtask

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0: out_ready = 1'b1;
            1: out_ready = ~out_ready;
            default: out_ready = ($urandom_range(0, 3) != 0);
        endcase
    end

    exp_t prev;
    bit   prev_stall = 0;
    always @(negedge clk) begin
        exp_t got;
        exp_t exp;
        got.data = out_data; got.empty = out_empty; got.sop = out_sop; got.eop = out_eop;
        got.gvld = get_valid; got.gdat = get_data; got.ghit = get_hit;
        if (rst) begin
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                checks++;
                if (!out_valid || got !== prev) begin
                    failures++;
                    $display("FAIL stall_stable actual_vld=%0b gd=%0h sop=%0b required gd=%0h sop=%0b",
                             out_valid, got.gdat, got.sop, prev.gdat, prev.sop);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_beat actual gd=%0h sop=%0b required none", got.gdat, got.sop);
                end else begin
                    exp = sb.pop_front();
                    if (got !== exp) begin
                        failures++;
                        $display("FAIL beat actual sop=%0b eop=%0b emp=%0h gv=%0b gd=%0h gh=%0b d=%0h required sop=%0b eop=%0b emp=%0h gv=%0b gd=%0h gh=%0b d=%0h",
                                 got.sop, got.eop, got.empty, got.gvld, got.gdat, got.ghit, got.data,
                                 exp.sop, exp.eop, exp.empty, exp.gvld, exp.gdat, exp.ghit, exp.data);
                    end
                end
            end
            prev_stall = out_valid && !out_ready;
            prev = got;
        end
    end

    logic [DW-1:0] d;
    initial begin
        // Reset values
        #2;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_get", {get_valid, get_hit, get_data}, 0);
        chk("rst_perr", 32'(proto_err), 0);
        chk("rst_cnt", {pkt_count, hit_count}, 0);
        @(negedge clk); @(negedge clk);
        rst = 0;
        #1 chk("in_ready_low_after_release", 32'(in_ready), 0);
        cycle();
        chk("in_ready_rises", 32'(in_ready), 1);

        // Test 1: 3-beat packet, field 8'h11, exact match, 1-cycle latency
        d = rand_data(); d[7:0] = 8'h11;
        send_beat(d, 1, 0, 8'h11, 8'hFF);
        chk("latency_out_valid", 32'(out_valid), 1);
        chk("latency_get_data", 32'(get_data), 32'h11);
        send_beat(rand_data(), 0, 0, 8'h55, 8'hFF);
        send_beat(rand_data(), 0, 1, 8'h66, 8'hFF);
        drain();
        chk("t1_pkt_count", 32'(pkt_count), 1);
        chk("t1_hit_count", 32'(hit_count), 1);

        // Test 2: mask/value variants; later match changes must not affect held packet
        for (int v = 0; v < 3; v++) begin
            logic [GW-1:0] mv, mm;
            mv = (v == 0) ? 8'h22 : 8'h11;
            mm = (v == 0) ? 8'hF0 : (v == 1) ? 8'h0F : 8'h00;
            d = rand_data(); d[7:0] = 8'h11;
            send_beat(d, 1, 0, mv, mm);
            send_beat(rand_data(), 0, 0, GW'($urandom), GW'($urandom));
            send_beat(rand_data(), 0, 1, GW'($urandom), GW'($urandom));
        end
        drain();
        chk("t2_hit_count", 32'(hit_count), 3);

        // Test 3: back-to-back single-beat packets with toggling out_ready
        ready_mode = 1;
        for (int i = 0; i < 30; i++) begin
            d = rand_data();
            send_beat(d, 1, 1, d[7:0] ^ GW'($urandom_range(0, 1)), 8'hFF);
        end
        drain();
        ready_mode = 0;

        // Test 4: non-SOP in IDLE, then SOP inside packet
        send_beat(rand_data(), 0, 0, 8'h00, 8'h00);
        send_beat(rand_data(), 0, 1, 8'h00, 8'h00);
        d = rand_data(); d[7:0] = 8'hA5;
        send_beat(d, 1, 0, 8'hA5, 8'hFF);
        send_beat(rand_data(), 0, 0, 8'h00, 8'hFF);
        d = rand_data(); d[7:0] = 8'h3C;
        send_beat(d, 1, 0, 8'h00, 8'hFF);
        send_beat(rand_data(), 0, 1, 8'h00, 8'hFF);
        drain();

        // Random traffic with random backpressure
        ready_mode = 2;
        for (int i = 0; i < 200; i++) begin
            d = rand_data();
            send_beat(d, $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
                      GW'($urandom_range(0, 1) ? d[7:0] : GW'($urandom)), GW'($urandom));
            if ($urandom_range(0, 7) == 0) idle(1);
        end
        drain();
        ready_mode = 0;

        // Test 5: saturation with 20 always-hit packets
        for (int i = 0; i < 20; i++) send_beat(rand_data(), 1, 1, GW'($urandom), 8'h00);
        drain();
        chk("sat_pkt_count", 32'(pkt_count), 32'hF);
        chk("sat_hit_count", 32'(hit_count), 32'hF);

        // Reset mid-packet under backpressure
        ready_mode = 2;
        send_beat(rand_data(), 1, 0, 8'h00, 8'h00);
        send_beat(rand_data(), 0, 0, 8'h00, 8'h00);
        in_valid = 1; in_sop = 0; in_eop = 0;
        @(posedge clk); #3;
        rst = 1;
        in_valid = 0;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 0);
        chk("midrst_in_ready", 32'(in_ready), 0);
        chk("midrst_cnt", {pkt_count, hit_count}, 0);
        chk("midrst_perr", 32'(proto_err), 0);
        sb.delete();
        m_inpkt = 0; m_pkt = 0; m_hits = 0; exp_perr = 0;
        ready_mode = 0;
        @(negedge clk); @(negedge clk);
        rst = 0;
        cycle();
        d = rand_data(); d[7:0] = 8'h7E;
        send_beat(d, 1, 0, 8'h7E, 8'hFF);
        send_beat(rand_data(), 0, 1, 8'h00, 8'h00);
        drain();
        chk("post_rst_pkt_count", 32'(pkt_count), 1);
        chk("post_rst_hit_count", 32'(hit_count), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end
endmodule
